// File: rtl/xcore_soc.sv
// Single-cycle RV32I-subset system: combinational instruction ROM, combinational-read data RAM,
// 32-entry register file. Only clk/rst cross the boundary; the image is preloaded into u_rom._rom.

module xcore_rom #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic [AW-1:0] addr,
    output logic [31:0]   data
);
    // Contents come from the program image via a hierarchical preload; no write port.
    logic [31:0] _rom [0:DEPTH-1];

    assign data = _rom[addr];
endmodule

module xcore_soc #(
    parameter int          ROM_DEPTH = 4096,
    parameter int          RAM_DEPTH = 4096,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic clk,
    input  logic rst
);
    localparam int RW = $clog2(ROM_DEPTH);
    localparam int MW = $clog2(RAM_DEPTH);

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6f;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    logic [31:0] pc;
    logic        halted;
    logic [31:0] regs [0:31];
    logic [31:0] ram  [0:RAM_DEPTH-1];

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] mem_addr;
    logic [31:0] next_pc;
    logic [31:0] wb_data;
    logic        wb_en;
    logic        mem_we;
    logic        halt_req;

    xcore_rom #(.DEPTH(ROM_DEPTH)) u_rom (
        .addr (pc[RW+1:2]),
        .data (instr)
    );

    function automatic logic [31:0] alu(input logic [2:0] op, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        alu = '0;
        case (op)
            3'd0: alu = alt ? a - b : a + b;
            3'd1: alu = a << b[4:0];
            3'd2: alu = {31'b0, sa < sb};
            3'd3: alu = {31'b0, a < b};
            3'd4: alu = a ^ b;
            3'd5: begin
                // Kept out of a ternary so the arithmetic shift stays in a signed context.
                if (alt) alu = sa >>> b[4:0];
                else     alu = a >> b[4:0];
            end
            3'd6: alu = a | b;
            default: alu = a & b;
        endcase
    endfunction

    function automatic logic branch_taken(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        case (op)
            3'd0:    branch_taken = (a == b);
            3'd1:    branch_taken = (a != b);
            3'd4:    branch_taken = (sa < sb);
            3'd5:    branch_taken = (sa >= sb);
            3'd6:    branch_taken = (a < b);
            3'd7:    branch_taken = (a >= b);
            default: branch_taken = 1'b0;
        endcase
    endfunction

    assign opcode  = instr[6:0];
    assign rd      = instr[11:7];
    assign funct3  = instr[14:12];
    assign rs1     = instr[19:15];
    assign rs2     = instr[24:20];
    assign imm_i   = {{20{instr[31]}}, instr[31:20]};
    assign imm_s   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u   = {instr[31:12], 12'b0};
    assign imm_j   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
    assign mem_addr = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);

    always_comb begin
        next_pc  = pc + 32'd4;
        wb_en    = 1'b0;
        wb_data  = '0;
        mem_we   = 1'b0;
        halt_req = 1'b0;
        case (opcode)
            OP_LUI: begin
                wb_en   = 1'b1;
                wb_data = imm_u;
            end
            OP_AUIPC: begin
                wb_en   = 1'b1;
                wb_data = pc + imm_u;
            end
            OP_JAL: begin
                wb_en   = 1'b1;
                wb_data = pc + 32'd4;
                next_pc = pc + imm_j;
            end
            OP_JALR: begin
                wb_en   = 1'b1;
                wb_data = pc + 32'd4;
                next_pc = (rs1_val + imm_i) & ~32'd1;
            end
            OP_BRANCH: begin
                if (branch_taken(funct3, rs1_val, rs2_val)) next_pc = pc + imm_b;
            end
            OP_IMM: begin
                wb_en   = 1'b1;
                wb_data = alu(funct3, (funct3 == 3'd5) && instr[30], rs1_val, imm_i);
            end
            OP_REG: begin
                wb_en   = 1'b1;
                wb_data = alu(funct3, instr[30], rs1_val, rs2_val);
            end
            OP_LOAD: begin
                if (funct3 == 3'd2) begin
                    wb_en   = 1'b1;
                    wb_data = ram[mem_addr[MW+1:2]];
                end
            end
            OP_STORE: begin
                mem_we = (funct3 == 3'd2);
            end
            OP_SYSTEM: begin
                // ECALL and EBREAK both stop the core with pc parked on the instruction.
                if (instr == 32'h0000_0073 || instr == 32'h0010_0073) begin
                    halt_req = 1'b1;
                    next_pc  = pc;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= RESET_PC;
            halted <= 1'b0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (!halted) begin
            pc <= next_pc;
            if (halt_req) halted <= 1'b1;
            if (wb_en && rd != 5'd0) regs[rd] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !halted && mem_we) ram[mem_addr[MW+1:2]] <= rs2_val;
    end
endmodule

// File: tb/tb_xcore_soc.sv
// Directed bench for xcore_soc: preloads small programs into the ROM and checks architectural
// state (pc, registers, RAM, halted) against hand-computed values.

module tb_xcore_soc;
    logic clk;
    logic rst;
    int   checks;
    int   fails;
    int   wp;
    int   n;

    xcore_soc dut (
        .clk (clk),
        .rst (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] i_t(input int imm, input int rs1, input int f3,
                                        input int rd, input logic [6:0] op);
        logic [11:0] im;
        im = imm[11:0];
        return {im, rs1[4:0], f3[2:0], rd[4:0], op};
    endfunction

    function automatic logic [31:0] r_t(input int f7, input int rs2, input int rs1,
                                        input int f3, input int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction

    function automatic logic [31:0] s_t(input int imm, input int rs2, input int rs1, input int f3);
        logic [11:0] im;
        im = imm[11:0];
        return {im[11:5], rs2[4:0], rs1[4:0], f3[2:0], im[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] b_t(input int imm, input int rs2, input int rs1, input int f3);
        logic [12:0] im;
        im = imm[12:0];
        return {im[12], im[10:5], rs2[4:0], rs1[4:0], f3[2:0], im[4:1], im[11], 7'h63};
    endfunction

    function automatic logic [31:0] j_t(input int imm, input int rd);
        logic [20:0] im;
        im = imm[20:0];
        return {im[20], im[10:1], im[11], im[19:12], rd[4:0], 7'h6f};
    endfunction

    function automatic logic [31:0] u_t(input int imm, input int rd, input logic [6:0] op);
        return {imm[19:0], rd[4:0], op};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 4096; i++) dut.u_rom._rom[i] = 32'h0;
        wp = 0;
    endtask

    task automatic put(input logic [31:0] w);
        dut.u_rom._rom[wp] = w;
        wp++;
    endtask

    task automatic run_to_halt(input string tag, input int exp_cycles);
        n = 0;
        while (!dut.halted && n < 200) begin
            step();
            n++;
        end
        check(tag, 32'(n), 32'(exp_cycles));
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        rst    = 1'b1;

        // Program 1: ALU, x0, LUI/AUIPC, store/load
        clear_rom();
        put(i_t(5, 0, 0, 1, 7'h13));        // 0  addi x1,x0,5
        put(i_t(-3, 0, 0, 2, 7'h13));       // 1  addi x2,x0,-3
        put(r_t(0, 2, 1, 0, 3));            // 2  add  x3,x1,x2
        put(r_t(7'h20, 1, 2, 0, 4));        // 3  sub  x4,x2,x1
        put(r_t(0, 2, 1, 3, 5));            // 4  sltu x5,x1,x2
        put(i_t(7, 0, 0, 0, 7'h13));        // 5  addi x0,x0,7
        put(r_t(0, 0, 0, 0, 6));            // 6  add  x6,x0,x0
        put(i_t(12'h401, 2, 5, 8, 7'h13));  // 7  srai x8,x2,1
        put(i_t(28, 2, 5, 10, 7'h13));      // 8  srli x10,x2,28
        put(r_t(0, 1, 2, 2, 11));           // 9  slt  x11,x2,x1
        put(u_t(20'h12345, 12, 7'h37));     // 10 lui  x12,0x12345
        put(u_t(1, 13, 7'h17));             // 11 auipc x13,1
        put(i_t(12'h55, 0, 0, 1, 7'h13));   // 12 addi x1,x0,0x55
        put(s_t(8, 1, 0, 2));               // 13 sw   x1,8(x0)
        put(i_t(8, 0, 2, 7, 7'h03));        // 14 lw   x7,8(x0)
        put(32'h0000_0073);                 // 15 ecall

        repeat (5) step();
        check("reset_pc", dut.pc, 32'h0);
        check("reset_halted", {31'b0, dut.halted}, 32'h0);
        for (int i = 0; i < 32; i++) check($sformatf("reset_x%0d", i), dut.regs[i], 32'h0);
        check("first_fetch", dut.u_rom.data, i_t(5, 0, 0, 1, 7'h13));

        rst = 1'b0;
        step();
        check("p1_x1_after_1", dut.regs[1], 32'd5);
        check("p1_pc_after_1", dut.pc, 32'h4);
        run_to_halt("p1_cycles", 15);
        check("p1_x2", dut.regs[2], 32'hFFFF_FFFD);
        check("p1_x3", dut.regs[3], 32'h2);
        check("p1_x4", dut.regs[4], 32'hFFFF_FFF8);
        check("p1_x5", dut.regs[5], 32'h1);
        check("p1_x0", dut.regs[0], 32'h0);
        check("p1_x6", dut.regs[6], 32'h0);
        check("p1_x8_srai", dut.regs[8], 32'hFFFF_FFFE);
        check("p1_x10_srli", dut.regs[10], 32'hF);
        check("p1_x11_slt", dut.regs[11], 32'h1);
        check("p1_x12_lui", dut.regs[12], 32'h1234_5000);
        check("p1_x13_auipc", dut.regs[13], 32'h0000_102C);
        check("p1_ram2", dut.ram[2], 32'h55);
        check("p1_x7_lw", dut.regs[7], 32'h55);
        check("p1_pc_halt", dut.pc, 32'h3C);

        // Program 2: control flow
        rst = 1'b1;
        step();
        clear_rom();
        put(i_t(3, 0, 0, 1, 7'h13));        // 0  addi x1,x0,3
        put(i_t(-1, 1, 0, 1, 7'h13));       // 1  addi x1,x1,-1
        put(b_t(-4, 0, 1, 1));              // 2  bne  x1,x0,-4
        put(j_t(8, 9));                     // 3  jal  x9,+8
        put(i_t(99, 0, 0, 20, 7'h13));      // 4  addi x20,x0,99 (skipped)
        put(i_t(29, 0, 0, 21, 7'h67));      // 5  jalr x21,29(x0) -> 28
        put(i_t(1, 0, 0, 22, 7'h13));       // 6  addi x22,x0,1 (skipped)
        put(b_t(8, 0, 0, 0));               // 7  beq  x0,x0,+8
        put(i_t(1, 0, 0, 23, 7'h13));       // 8  addi x23,x0,1 (skipped)
        put(32'h0000_0073);                 // 9  ecall
        step();
        rst = 1'b0;
        run_to_halt("p2_cycles", 11);
        check("p2_x1", dut.regs[1], 32'h0);
        check("p2_x9_link", dut.regs[9], 32'h10);
        check("p2_x20_skipped", dut.regs[20], 32'h0);
        check("p2_x21_link", dut.regs[21], 32'h18);
        check("p2_x22_skipped", dut.regs[22], 32'h0);
        check("p2_x23_skipped", dut.regs[23], 32'h0);
        check("p2_pc_halt", dut.pc, 32'h24);

        // Program 3: halt, hold, reset out of halt and mid-program
        rst = 1'b1;
        step();
        clear_rom();
        put(i_t(1, 0, 0, 1, 7'h13));        // 0  addi x1,x0,1
        put(i_t(2, 0, 0, 2, 7'h13));        // 1  addi x2,x0,2
        put(r_t(0, 2, 1, 0, 3));            // 2  add  x3,x1,x2
        put(32'h0000_0000);                 // 3  all-zero word: no-op
        put(32'h0000_0073);                 // 4  ecall
        put(i_t(9, 0, 0, 4, 7'h13));        // 5  addi x4,x0,9 (never reached)
        step();
        rst = 1'b0;
        run_to_halt("p3_cycles", 5);
        check("p3_halted", {31'b0, dut.halted}, 32'h1);
        check("p3_x3", dut.regs[3], 32'h3);
        for (int i = 0; i < 100; i++) begin
            step();
            check("p3_pc_hold", dut.pc, 32'h10);
        end
        check("p3_still_halted", {31'b0, dut.halted}, 32'h1);
        check("p3_x4_untouched", dut.regs[4], 32'h0);

        rst = 1'b1;
        step();
        check("p3_rst_pc", dut.pc, 32'h0);
        check("p3_rst_halted", {31'b0, dut.halted}, 32'h0);
        check("p3_rst_x3", dut.regs[3], 32'h0);
        rst = 1'b0;
        step();
        check("p3_restart_x1", dut.regs[1], 32'h1);
        check("p3_restart_pc", dut.pc, 32'h4);
        step();
        check("p3_restart_x2", dut.regs[2], 32'h2);
        rst = 1'b1;
        step();
        check("p3_abort_x3", dut.regs[3], 32'h0);
        check("p3_abort_pc", dut.pc, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
